// File: rtl/mem_arbiter_if.sv
// Bundle of cache-side request/response and MainMem-side command signals.
// The arbiter takes the slave view; the surrounding system takes the master view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
);
    logic              ic_read;
    logic [ADDR_W-1:0] ic_addr;
    logic [DATA_W-1:0] ic_rdata;
    logic              ic_ready;

    logic              dc_read;
    logic              dc_write;
    logic [ADDR_W-1:0] dc_addr;
    logic [DATA_W-1:0] dc_wdata;
    logic [DATA_W-1:0] dc_rdata;
    logic              dc_ready;

    logic              mem_oe;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              busy;
    logic              timeout_err;

    modport slave (
        input  ic_read, ic_addr,
        input  dc_read, dc_write, dc_addr, dc_wdata,
        input  mem_rdata, mem_ready,
        output ic_rdata, ic_ready,
        output dc_rdata, dc_ready,
        output mem_oe, mem_we, mem_addr, mem_wdata,
        output busy, timeout_err
    );

    modport master (
        output ic_read, ic_addr,
        output dc_read, dc_write, dc_addr, dc_wdata,
        output mem_rdata, mem_ready,
        input  ic_rdata, ic_ready,
        input  dc_rdata, dc_ready,
        input  mem_oe, mem_we, mem_addr, mem_wdata,
        input  busy, timeout_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one MainMem port between icache and dcache,
// with registered command/response and a per-grant watchdog.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 128,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           reset,
    mem_arbiter_if.slave   bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] GRANT_IC = 2'd1;
    localparam logic [1:0] GRANT_DC = 2'd2;
    localparam logic [1:0] RELEASE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              last_dc_q, last_dc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              oe_q, oe_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] ic_rdata_q, ic_rdata_d;
    logic [DATA_W-1:0] dc_rdata_q, dc_rdata_d;
    logic              ic_ready_q, ic_ready_d;
    logic              dc_ready_q, dc_ready_d;
    logic              tmo_q, tmo_d;

    logic ic_req;
    logic dc_req;
    logic pick_dc;
    logic done;
    logic expired;

    assign ic_req  = bus.ic_read;
    assign dc_req  = bus.dc_read | bus.dc_write;
    // On a tie the port that did not win last time goes first.
    assign pick_dc = dc_req & (~ic_req | ~last_dc_q);
    assign done    = bus.mem_ready;
    assign expired = ~bus.mem_ready & (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        last_dc_d  = last_dc_q;
        cnt_d      = cnt_q;
        oe_d       = oe_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ic_rdata_d = ic_rdata_q;
        dc_rdata_d = dc_rdata_q;
        ic_ready_d = 1'b0;
        dc_ready_d = 1'b0;
        tmo_d      = tmo_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (ic_req | dc_req) begin
                    if (pick_dc) begin
                        state_d   = GRANT_DC;
                        last_dc_d = 1'b1;
                        addr_d    = bus.dc_addr;
                        wdata_d   = bus.dc_wdata;
                        we_d      = bus.dc_write;
                        oe_d      = ~bus.dc_write;
                    end else begin
                        state_d   = GRANT_IC;
                        last_dc_d = 1'b0;
                        addr_d    = bus.ic_addr;
                        we_d      = 1'b0;
                        oe_d      = 1'b1;
                    end
                end
            end
            GRANT_IC, GRANT_DC: begin
                if (done | expired) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                    oe_d    = 1'b0;
                    we_d    = 1'b0;
                    if (state_q == GRANT_IC) begin
                        ic_ready_d = 1'b1;
                        if (expired)
                            ic_rdata_d = '0;
                        else if (oe_q)
                            ic_rdata_d = bus.mem_rdata;
                    end else begin
                        dc_ready_d = 1'b1;
                        if (expired)
                            dc_rdata_d = '0;
                        else if (oe_q)
                            dc_rdata_d = bus.mem_rdata;
                    end
                    if (expired)
                        tmo_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            last_dc_q  <= 1'b0;
            cnt_q      <= '0;
            oe_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ic_rdata_q <= '0;
            dc_rdata_q <= '0;
            ic_ready_q <= 1'b0;
            dc_ready_q <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_dc_q  <= last_dc_d;
            cnt_q      <= cnt_d;
            oe_q       <= oe_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ic_rdata_q <= ic_rdata_d;
            dc_rdata_q <= dc_rdata_d;
            ic_ready_q <= ic_ready_d;
            dc_ready_q <= dc_ready_d;
            tmo_q      <= tmo_d;
        end
    end

    assign bus.ic_rdata    = ic_rdata_q;
    assign bus.ic_ready    = ic_ready_q;
    assign bus.dc_rdata    = dc_rdata_q;
    assign bus.dc_ready    = dc_ready_q;
    assign bus.mem_oe      = oe_q;
    assign bus.mem_we      = we_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.timeout_err = tmo_q;
endmodule
